// File: rtl/vend_pkg.sv
// Shared types, coin values and price lookup for the vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam int unsigned COIN_W = 3;

    localparam logic [COIN_W-1:0] NICKEL  = 3'd1;
    localparam logic [COIN_W-1:0] DIME    = 3'd2;
    localparam logic [COIN_W-1:0] QUARTER = 3'd5;

    localparam int unsigned PRICE_VEC_W = 256;
    localparam int unsigned PRICE_MAX_W = 16;

    // Extract entry idx of width w from a flat, zero-extended price vector.
    function automatic logic [PRICE_MAX_W-1:0] price_at(
        input logic [PRICE_VEC_W-1:0] prices,
        input int unsigned            idx,
        input int unsigned            w
    );
        logic [PRICE_VEC_W-1:0] shifted;
        shifted = prices >> (idx * w);
        return PRICE_MAX_W'(shifted) & PRICE_MAX_W'((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/vend_coin_decode.sv
// One-hot check of the coin strobes; yields the accepted coin value.
module vend_coin_decode
    import vend_pkg::*;
(
    input  logic              n,
    input  logic              d,
    input  logic              q,
    output logic              coin_valid,
    output logic              multi_coin,
    output logic [COIN_W-1:0] coin_value
);

    always_comb begin
        coin_valid = 1'b0;
        multi_coin = 1'b0;
        coin_value = '0;
        unique case ({q, d, n})
            3'b000: ;
            3'b001: begin coin_valid = 1'b1; coin_value = NICKEL;  end
            3'b010: begin coin_valid = 1'b1; coin_value = DIME;    end
            3'b100: begin coin_valid = 1'b1; coin_value = QUARTER; end
            default: multi_coin = 1'b1;
        endcase
    end

endmodule

// File: rtl/vend_ctrl.sv
// Parametrised vending controller: credit, vend handshake, nickel change.
// Optional cancel/refund input enabled by defining VEND_CANCEL_EN.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W   = 5,
    parameter int unsigned MAX_CREDIT = 20,
    parameter int unsigned NUM_PROD   = 3,
    parameter int unsigned SEL_W      = 2,
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = {5'd6, 5'd4, 5'd2}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                n,
    input  logic                d,
    input  logic                q,
    input  logic                D,
    input  logic [SEL_W-1:0]    sel,
    input  logic                disp_ready,
    output logic                disp_valid,
    output logic [SEL_W-1:0]    disp_id,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                deny,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
`ifdef VEND_CANCEL_EN
    ,
    input  logic                cancel
`endif
);

    localparam int unsigned SUM_W = CREDIT_W + 1;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_d;
    logic [SEL_W-1:0]    disp_id_d;
    logic                disp_valid_d, change_pulse_d, coin_reject_d, deny_d, busy_d;

    logic                coin_valid, multi_coin, any_coin;
    logic [COIN_W-1:0]   coin_value;
    logic [SUM_W-1:0]    coin_sum;
    logic                coin_fits;
    logic [CREDIT_W-1:0] sel_price;
    logic                vend_ok;
    logic                cancel_req;

`ifdef VEND_CANCEL_EN
    assign cancel_req = cancel;
`else
    assign cancel_req = 1'b0;
`endif

    vend_coin_decode u_coin_decode (
        .n          (n),
        .d          (d),
        .q          (q),
        .coin_valid (coin_valid),
        .multi_coin (multi_coin),
        .coin_value (coin_value)
    );

    assign any_coin  = coin_valid | multi_coin;
    assign coin_sum  = SUM_W'(credit) + SUM_W'(coin_value);
    assign coin_fits = coin_sum <= SUM_W'(MAX_CREDIT);
    // Out-of-range selects read zero-padding, but sel range is checked before use.
    assign sel_price = CREDIT_W'(price_at(PRICE_VEC_W'(PRICES), 32'(sel), CREDIT_W));
    assign vend_ok   = D && (32'(sel) < NUM_PROD) && (credit >= sel_price);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            credit       <= '0;
            disp_valid   <= 1'b0;
            disp_id      <= '0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            deny         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit       <= credit_d;
            disp_valid   <= disp_valid_d;
            disp_id      <= disp_id_d;
            change_pulse <= change_pulse_d;
            coin_reject  <= coin_reject_d;
            deny         <= deny_d;
            busy         <= busy_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        credit_d       = credit;
        disp_valid_d   = 1'b0;
        disp_id_d      = '0;
        change_pulse_d = 1'b0;
        coin_reject_d  = 1'b0;
        deny_d         = 1'b0;

        unique case (state_q)
            IDLE, ACCUM: begin
                if (cancel_req && state_q == ACCUM) begin
                    state_d       = CHANGE;
                    coin_reject_d = any_coin;
                end else if (vend_ok) begin
                    // Vend wins over a same-cycle coin; price taken from pre-coin credit.
                    state_d       = VEND;
                    credit_d      = credit - sel_price;
                    disp_valid_d  = 1'b1;
                    disp_id_d     = sel;
                    coin_reject_d = any_coin;
                end else begin
                    deny_d = D;
                    if (multi_coin || (coin_valid && !coin_fits)) begin
                        coin_reject_d = 1'b1;
                    end else if (coin_valid) begin
                        credit_d = CREDIT_W'(coin_sum);
                        state_d  = ACCUM;
                    end
                end
            end
            VEND: begin
                coin_reject_d = any_coin;
                if (disp_ready) begin
                    state_d = (credit != '0) ? CHANGE : IDLE;
                end else begin
                    disp_valid_d = 1'b1;
                    disp_id_d    = disp_id;
                end
            end
            CHANGE: begin
                coin_reject_d = any_coin;
                if (credit != '0) begin
                    change_pulse_d = 1'b1;
                    credit_d       = credit - CREDIT_W'(1);
                    if (credit == CREDIT_W'(1)) state_d = IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == VEND) || (state_d == CHANGE);
    end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
Parametrised vending controller; successor to the fixed 3-product nickel/dime/quarter FSM. Accumulates credit in nickel units, vends any of NUM_PROD products with per-product prices, and returns change one nickel per cycle. Dispense uses a valid/ready handshake to the mechanism driver; sits between the coin acceptor front-end and the dispenser/coin-return actuators.

Parameters:
CREDIT_W, 5, credit register width in nickel units
MAX_CREDIT, 20, credit ceiling in nickels (20 = $1.00); must be < 2**CREDIT_W
NUM_PROD, 3, number of products
SEL_W, 2, product select width; 2**SEL_W >= NUM_PROD
PRICES, {5'd6,5'd4,5'd2}, flat NUM_PROD*CREDIT_W vector; product k price at bits [k*CREDIT_W +: CREDIT_W], nickel units; every entry must be >= 1

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
n  in  1  nickel inserted (1-cycle pulse, value 1)
d  in  1  dime inserted (value 2)
q  in  1  quarter inserted (value 5)
D  in  1  done/vend request for product sel
sel  in  SEL_W  product index, sampled with D
disp_ready  in  1  dispenser accepts product
disp_valid  out  1  product dispense request
disp_id  out  SEL_W  product being dispensed
change_pulse  out  1  one nickel returned this cycle
coin_reject  out  1  coin(s) returned unaccepted this cycle
deny  out  1  vend request refused this cycle
credit  out  CREDIT_W  current credit
busy  out  1  high in VEND or CHANGE

Behaviour:
- All outputs registered. Reset (sampled at clk edge): state IDLE, credit 0, all outputs 0. Reset mid-VEND/CHANGE aborts; credit forfeited, no change pulses.
- States: IDLE (credit==0), ACCUM (credit>0), VEND, CHANGE.
- Coin accept (IDLE/ACCUM): exactly one of n/d/q high at edge t -> credit += value at t+1; IDLE->ACCUM.
- More than one coin high same cycle -> all rejected: coin_reject=1 at t+1, credit unchanged.
- credit+value > MAX_CREDIT -> coin rejected (coin_reject=1), credit unchanged; no wrap.
- Coins arriving in VEND or CHANGE -> coin_reject=1.
- Coin and D in same cycle in ACCUM: D evaluated against pre-coin credit; coin rejected if D is accepted, otherwise coin accepted normally.
- D in IDLE/ACCUM: if sel < NUM_PROD and credit >= PRICES[sel] -> at t+1 state VEND, disp_valid=1, disp_id=sel, credit = credit - price. Else deny=1 for one cycle, state/credit unchanged.
- VEND: disp_valid/disp_id held until disp_ready sampled high; next cycle disp_valid=0 and state -> CHANGE if credit>0 else IDLE. D ignored in VEND/CHANGE.
- CHANGE: change_pulse=1 every cycle, credit decrements by 1 per pulse; pulse count equals remaining credit exactly; after credit reaches 0, next state IDLE, change_pulse=0.
- coin_reject, deny, change_pulse are single-cycle per event.

Optional Feature:
VEND_CANCEL_EN: adds input port cancel (1 bit). Defined: cancel in ACCUM enters CHANGE, refunding full credit one nickel per cycle; cancel in IDLE/VEND/CHANGE ignored; cancel with D same cycle -> cancel wins, deny=0. Undefined: no cancel port; credit persists in ACCUM until a vend.

Decomposition:
Package vend_pkg: state enum (IDLE, ACCUM, VEND, CHANGE), coin value localparams (NICKEL=1, DIME=2, QUARTER=5), price-extract function. Sub-module vend_coin_decode: combinational one-hot check of n/d/q producing coin_valid, multi_coin and coin_value; instantiated once.

Test Plan:
Reset, then d,d (2 cycles), D with sel=0 (price 2) -> credit 2 then 4, disp_valid=1 disp_id=0, after disp_ready: 2 change_pulse cycles, credit 0, IDLE.
n,d,q in one cycle -> coin_reject=1, credit stays 0; then q,q,q,q, n -> fourth q lands credit 20, n rejected at MAX_CREDIT.
credit 3, D sel=1 (price 4) -> deny=1 one cycle, credit 3; sel=3 (out of range) -> deny=1.
Vend with disp_ready low 5 cycles -> disp_valid held 5+ cycles, coins during this get coin_reject, no credit change.
Assert reset during CHANGE with 3 nickels pending -> next cycle all outputs 0, no further change_pulse.
VEND_CANCEL_EN defined: credit 7, cancel -> exactly 7 change_pulse cycles, then IDLE; cancel+D same cycle -> refund, no dispense.
